// File: rtl/captura_teclas_7.sv
// Push-button front end for the 7-to-3 encoder: synchronises and debounces
// seven raw lines and presents a registered one-hot code (or zero) with a press pulse.
module captura_teclas_7 #(
  parameter int DEB_CICLOS = 50000,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Botones,
  output logic [6:0] Salida,
  output logic       Valido,
  output logic       Error
);

  typedef enum logic [1:0] {
    REPOSO     = 2'd0,
    FILTRO     = 2'd1,
    PRESIONADO = 2'd2,
    SOLTANDO   = 2'd3
  } estado_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CICLOS - 1);
  localparam logic [CNT_W-1:0] CNT_UNO = CNT_W'(1);

  // A code is forwardable only when exactly one key is down.
  function automatic logic es_one_hot(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

  logic [6:0]       r_s1;
  logic [6:0]       r_s2;
  logic [6:0]       w_sinc;
  estado_t          r_estado;
  estado_t          w_estado_sig;
  logic [6:0]       r_muestra;
  logic [6:0]       w_muestra_sig;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_sig;
  logic [6:0]       r_salida;
  logic [6:0]       w_salida_sig;
  logic             r_valido;
  logic             w_valido_sig;
  logic             r_error;
  logic             w_error_sig;

  assign w_sinc = r_s2;
  assign Salida = r_salida;
  assign Valido = r_valido;
  assign Error  = r_error;

  // Two-flop synchroniser for the asynchronous button lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 7'd0;
      r_s2 <= 7'd0;
    end else begin
      r_s1 <= Botones;
      r_s2 <= r_s1;
    end
  end

  // State, filter sample, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado  <= REPOSO;
      r_muestra <= 7'd0;
      r_cnt     <= '0;
      r_salida  <= 7'd0;
      r_valido  <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_estado  <= w_estado_sig;
      r_muestra <= w_muestra_sig;
      r_cnt     <= w_cnt_sig;
      r_salida  <= w_salida_sig;
      r_valido  <= w_valido_sig;
      r_error   <= w_error_sig;
    end
  end

  // Debounce FSM: next state and next register values.
  always_comb begin
    w_estado_sig  = r_estado;
    w_muestra_sig = r_muestra;
    w_cnt_sig     = r_cnt;
    w_salida_sig  = r_salida;
    w_valido_sig  = 1'b0;
    w_error_sig   = r_error;
    case (r_estado)
      REPOSO: begin
        w_salida_sig = 7'd0;
        w_error_sig  = 1'b0;
        if (w_sinc != 7'd0) begin
          w_muestra_sig = w_sinc;
          w_cnt_sig     = '0;
          w_estado_sig  = FILTRO;
        end else begin
          w_estado_sig  = REPOSO;
        end
      end
      FILTRO: begin
        if (w_sinc == 7'd0) begin
          w_estado_sig  = REPOSO;
        end else if (w_sinc != r_muestra) begin
          w_muestra_sig = w_sinc;
          w_cnt_sig     = '0;
        end else if (r_cnt < CNT_MAX) begin
          w_cnt_sig     = r_cnt + CNT_UNO;
        end else if (es_one_hot(r_muestra)) begin
          w_salida_sig  = r_muestra;
          w_valido_sig  = 1'b1;
          w_estado_sig  = PRESIONADO;
        end else begin
          w_salida_sig  = 7'd0;
          w_error_sig   = 1'b1;
          w_estado_sig  = PRESIONADO;
        end
      end
      PRESIONADO: begin
        if (w_sinc == 7'd0) begin
          w_cnt_sig    = '0;
          w_estado_sig = SOLTANDO;
        end else begin
          w_estado_sig = PRESIONADO;
        end
      end
      SOLTANDO: begin
        // Any set bit here is release bounce, so the held code stays.
        if (w_sinc != 7'd0) begin
          w_estado_sig = PRESIONADO;
        end else if (r_cnt < CNT_MAX) begin
          w_cnt_sig    = r_cnt + CNT_UNO;
        end else begin
          w_salida_sig = 7'd0;
          w_error_sig  = 1'b0;
          w_estado_sig = REPOSO;
        end
      end
      default: begin
        w_estado_sig = REPOSO;
        w_salida_sig = 7'd0;
        w_error_sig  = 1'b0;
        w_cnt_sig    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_captura_teclas_7.sv
// Randomised and directed bench for captura_teclas_7 against a run-length
// reference model of the debounce rules (DEB_CICLOS=4).
module tb_captura_teclas_7;
  localparam int DEB = 4;

  logic       clk;
  logic       rst;
  logic [6:0] Botones;
  logic [6:0] Salida;
  logic       Valido;
  logic       Error;

  captura_teclas_7 #(.DEB_CICLOS(DEB), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .Botones(Botones),
    .Salida(Salida), .Valido(Valido), .Error(Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;

  // Model state: synchroniser image plus run lengths of the sampled code.
  logic [6:0] m1, m2;
  logic [6:0] run_val;
  int         run_cnt, zero_cnt;
  bit         pressed;
  logic [6:0] exp_s;
  logic       exp_v, exp_e;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m1 = 7'd0; m2 = 7'd0; run_val = 7'd0; run_cnt = 0; zero_cnt = 0;
    pressed = 1'b0; exp_s = 7'd0; exp_v = 1'b0; exp_e = 1'b0;
  endtask

  // A press is accepted after DEB+1 identical nonzero samples; a release after DEB+1 zeros.
  task automatic model_step(input logic [6:0] smp);
    exp_v = 1'b0;
    if (!pressed) begin
      if (smp == 7'd0) run_cnt = 0;
      else if (run_cnt > 0 && smp == run_val) run_cnt++;
      else begin run_val = smp; run_cnt = 1; end
      if (run_cnt == DEB + 1) begin
        pressed = 1'b1; zero_cnt = 0; run_cnt = 0;
        if ($countones(run_val) == 1) begin exp_s = run_val; exp_v = 1'b1; end
        else exp_e = 1'b1;
      end
    end else begin
      if (smp != 7'd0) zero_cnt = 0;
      else zero_cnt++;
      if (zero_cnt == DEB + 1) begin
        pressed = 1'b0; exp_s = 7'd0; exp_e = 1'b0; run_cnt = 0;
      end
    end
  endtask

  task automatic cycle(input logic [6:0] b);
    logic [6:0] smp;
    Botones = b;
    @(posedge clk);
    smp = m2; m2 = m1; m1 = b;
    model_step(smp);
    #1;
    chk("salida", Salida, exp_s);
    chk("valido", {6'd0, Valido}, {6'd0, exp_v});
    chk("error", {6'd0, Error}, {6'd0, exp_e});
    if (Valido) n_valid++;
  endtask

  task automatic hold(input logic [6:0] b, input int n);
    for (int i = 0; i < n; i++) cycle(b);
  endtask

  // Reset pulse between edges; outputs must clear before the next edge.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_salida", Salida, 7'd0);
    chk("rst_valido", {6'd0, Valido}, 7'd0);
    chk("rst_error", {6'd0, Error}, 7'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [6:0] v;
    int         len;
    rst = 1'b1; Botones = 7'd0;
    model_reset();
    #12;
    chk("reset_salida", Salida, 7'd0);
    chk("reset_valido", {6'd0, Valido}, 7'd0);
    chk("reset_error", {6'd0, Error}, 7'd0);
    rst = 1'b0;
    #2;
    hold(7'd0, 3);

    // Clean press and release
    n_valid = 0;
    hold(7'b0000100, 20);
    hold(7'd0, 10);
    chk("t1_one_valid", 7'(n_valid), 7'd1);

    // Bounce then stable
    n_valid = 0;
    for (int i = 0; i < 5; i++) hold((i % 2 == 0) ? 7'b0000100 : 7'd0, 2);
    hold(7'b0000100, 12);
    hold(7'd0, 10);
    chk("t2_one_valid", 7'(n_valid), 7'd1);

    // Multi-key
    n_valid = 0;
    hold(7'b0010001, 12);
    hold(7'd0, 10);
    chk("t3_no_valid", 7'(n_valid), 7'd0);

    // Change during filtering
    n_valid = 0;
    hold(7'b0000001, 2);
    hold(7'b0000010, 12);
    hold(7'd0, 10);
    chk("t4_one_valid", 7'(n_valid), 7'd1);

    // Added key while held
    n_valid = 0;
    hold(7'b0000001, 10);
    hold(7'b0000011, 8);
    hold(7'd0, 10);
    chk("t5_one_valid", 7'(n_valid), 7'd1);

    // Reset in FILTRO, then in PRESIONADO
    n_valid = 0;
    hold(7'b0001000, 4);
    pulse_reset();
    hold(7'b0001000, 12);
    pulse_reset();
    hold(7'b0001000, 10);
    hold(7'd0, 10);
    chk("t6_valids", 7'(n_valid), 7'd2);

    // Random segments: mostly single keys, some gaps and chords, short holds bounce
    for (int s = 0; s < 400; s++) begin
      case ($urandom_range(0, 9))
        0, 1, 2:    v = 7'd0;
        3:          v = 7'($urandom_range(1, 127));
        default:    v = 7'd1 << $urandom_range(0, 6);
      endcase
      len = $urandom_range(1, 12);
      hold(v, len);
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end
    hold(7'd0, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
